// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one ALU op, drives the ripple ALU for a cycle and returns the captured result
module alu_issue_ctrl #(
  parameter int W = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [W-1:0]     rs_val,
  input  logic [W-1:0]     rt_val,
  input  logic [IMM_W-1:0] imm,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [W-1:0]     alu_r,
  input  logic             alu_c_out,
  input  logic             alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             carry,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic acc;
  logic [W-1:0] sext, zext, dec_a, dec_b;
  logic [2:0] dec_ctr;
  logic dec_ill, dec_beq, dec_bne;
  logic beq_q, bne_q, ill_q;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign acc = in_valid & in_ready;
  assign sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
  assign zext = {{(W-IMM_W){1'b0}}, imm};
  // decode opcode/funct into ALU control, operand B source and op kind; illegal ops drive zeros
  always_comb begin
    dec_ctr = 3'b000;
    dec_b = rt_val;
    dec_ill = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    case (opcode)
      6'h00:
        case (funct)
          6'h20: dec_ctr = 3'b010;
          6'h22: dec_ctr = 3'b110;
          6'h24: dec_ctr = 3'b000;
          6'h25: dec_ctr = 3'b001;
          6'h2A: dec_ctr = 3'b111;
          default: dec_ill = 1'b1;
        endcase
      6'h08: begin dec_ctr = 3'b010; dec_b = sext; end
      6'h0A: begin dec_ctr = 3'b111; dec_b = sext; end
      6'h0C: begin dec_ctr = 3'b000; dec_b = zext; end
      6'h0D: begin dec_ctr = 3'b001; dec_b = zext; end
      6'h04: begin dec_ctr = 3'b110; dec_beq = 1'b1; end
      6'h05: begin dec_ctr = 3'b110; dec_bne = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
    dec_a = dec_ill ? '0 : rs_val;
    if (dec_ill) begin
      dec_b = '0;
      dec_ctr = 3'b000;
    end
  end
  // next-state: accept in IDLE, one EXEC cycle, hold DONE until consumer takes the result
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = acc ? EXEC : IDLE;
      EXEC: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state, operand load on accept, and result/flag capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctr <= 3'b000;
      beq_q <= 1'b0;
      bne_q <= 1'b0;
      ill_q <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      branch_taken <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        alu_a <= dec_a;
        alu_b <= dec_b;
        alu_ctr <= dec_ctr;
        beq_q <= dec_beq;
        bne_q <= dec_bne;
        ill_q <= dec_ill;
      end
      if (state == EXEC) begin
        result <= ill_q ? '0 : alu_r;
        carry <= ~ill_q & alu_c_out;
        zero <= ~ill_q & alu_z;
        branch_taken <= (beq_q & alu_z) | (bne_q & ~alu_z);
        illegal <= ill_q;
      end
    end
  end
endmodule
